ccd_line_rx: RTL and testbench

Receive side of the CCD pixel output bus (pix_clk / pix_out_valid / pix_data) produced by the CCD timing generator. Resamples the bus into the clk_160M domain, frames pixels into lines using a programmable expected length, and buffers them in a small FIFO. The FIFO drains to a valid/ready stream feeding the line packer / USB path. Line-length errors and overflows are reported as status.

---
 rtl/ccd_line_rx.sv | 205 ++++++++++++++++++++
 tb/tb_ccd_line_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ccd_line_rx.sv
`default_nettype none
// ============================================================================
// Module      : ccd_line_rx
// Description : CCD pixel bus receiver. Resamples pix_clk/pix_out_valid into
//               clk_160M, frames pixels into lines and buffers them in a FIFO
//               that drains to a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ccd_line_rx #(
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 12
) (
    input  logic             clk_160M,
    input  logic             nrst,
    input  logic             en,
    input  logic [LEN_W-1:0] exp_len,
    input  logic             pix_clk,
    input  logic             pix_out_valid,
    input  logic [15:0]      pix_data,
    output logic [15:0]      m_data,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             line_done,
    output logic             line_err,
    output logic [LEN_W-1:0] line_len,
    output logic             ovf
);

    localparam int             c_aw      = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]  c_full    = (c_aw+1)'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

    localparam logic [2:0] c_s_idle = 3'd0;
    localparam logic [2:0] c_s_gap  = 3'd1;
    localparam logic [2:0] c_s_wait = 3'd2;
    localparam logic [2:0] c_s_line = 3'd3;
    localparam logic [2:0] c_s_post = 3'd4;

    logic [2:0]        r_state, w_state_nxt;
    logic              r_clk_s1, r_clk_s2, r_clk_s3, r_vld_s1, r_vld_s2;
    logic              w_sample;
    logic [LEN_W-1:0]  r_cnt, r_exp, r_line_len;
    logic [LEN_W-1:0]  w_cnt_nxt, w_cnt_inc, w_exp_eff, w_len_val;
    logic              r_post_err, w_post_err_nxt;
    logic              w_wr, w_wr_last, w_done, w_err, w_len_ld, w_exp_ld;
    logic              r_line_done, r_line_err;

    logic [16:0]       r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]     r_count, w_count_after_rd, w_count_nxt;
    logic              r_m_valid, r_ovf, w_full, w_wr_acc, w_rd;
    logic [16:0]       w_head;

    // pix_data is held stable for many cycles around the strobe edge, so only
    // the strobe and qualifier need synchronising.
    always_ff @(posedge clk_160M) begin
        if (!nrst) begin
            {r_clk_s1, r_clk_s2, r_clk_s3} <= 3'b000;
            {r_vld_s1, r_vld_s2}           <= 2'b00;
        end else begin
            {r_clk_s1, r_clk_s2, r_clk_s3} <= {pix_clk, r_clk_s1, r_clk_s2};
            {r_vld_s1, r_vld_s2}           <= {pix_out_valid, r_vld_s1};
        end
    end

    assign w_sample  = r_clk_s2 & ~r_clk_s3;
    assign w_cnt_inc = r_cnt + c_len_one;
    assign w_exp_eff = (exp_len == '0) ? c_len_one : exp_len;

    always_ff @(posedge clk_160M) begin
        if (!nrst) r_state <= c_s_idle;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = c_s_idle;
        end else begin
            case (r_state)
                c_s_idle: w_state_nxt = c_s_gap;
                c_s_gap:  if (w_sample && !r_vld_s2) w_state_nxt = c_s_wait;
                c_s_wait: if (w_sample && r_vld_s2)
                              w_state_nxt = (w_exp_eff == c_len_one) ? c_s_post : c_s_line;
                c_s_line: if (w_sample) begin
                              if (!r_vld_s2)               w_state_nxt = c_s_wait;
                              else if (w_cnt_inc == r_exp) w_state_nxt = c_s_post;
                          end
                c_s_post: if (w_sample && !r_vld_s2) w_state_nxt = c_s_wait;
                default:  w_state_nxt = c_s_idle;
            endcase
        end
    end

    always_comb begin
        w_wr           = 1'b0;
        w_wr_last      = 1'b0;
        w_done         = 1'b0;
        w_err          = 1'b0;
        w_len_ld       = 1'b0;
        w_len_val      = w_cnt_inc;
        w_cnt_nxt      = r_cnt;
        w_exp_ld       = 1'b0;
        w_post_err_nxt = r_post_err;
        if (!en) begin
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                c_s_wait: if (w_sample && r_vld_s2) begin
                    w_wr      = 1'b1;
                    w_cnt_nxt = c_len_one;
                    w_exp_ld  = 1'b1;
                    if (w_exp_eff == c_len_one) begin
                        w_wr_last      = 1'b1;
                        w_done         = 1'b1;
                        w_len_ld       = 1'b1;
                        w_len_val      = c_len_one;
                        w_post_err_nxt = 1'b0;
                    end
                end
                c_s_line: if (w_sample) begin
                    if (r_vld_s2) begin
                        w_wr      = 1'b1;
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == r_exp) begin
                            w_wr_last      = 1'b1;
                            w_done         = 1'b1;
                            w_len_ld       = 1'b1;
                            w_post_err_nxt = 1'b0;
                        end
                    end else begin
                        w_done    = 1'b1;
                        w_err     = 1'b1;
                        w_len_ld  = 1'b1;
                        w_len_val = r_cnt;
                        w_cnt_nxt = '0;
                    end
                end
                c_s_post: if (w_sample && r_vld_s2 && !r_post_err) begin
                    w_err          = 1'b1;
                    w_post_err_nxt = 1'b1;
                end
                default: w_cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk_160M) begin
        if (!nrst) begin
            r_cnt       <= '0;
            r_exp       <= c_len_one;
            r_post_err  <= 1'b0;
            r_line_done <= 1'b0;
            r_line_err  <= 1'b0;
            r_line_len  <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_post_err  <= w_post_err_nxt;
            r_line_done <= w_done;
            r_line_err  <= w_err;
            if (w_exp_ld) r_exp      <= w_exp_eff;
            if (w_len_ld) r_line_len <= w_len_val;
        end
    end

    assign w_full           = (r_count == c_full);
    assign w_wr_acc         = w_wr & ~w_full;
    assign w_rd             = r_m_valid & m_ready;
    assign w_count_after_rd = r_count - (c_aw+1)'(w_rd);
    assign w_count_nxt      = w_count_after_rd + (c_aw+1)'(w_wr_acc);

    always_ff @(posedge clk_160M) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= {w_wr_last, pix_data};
    end

    // m_valid only sees entries present before this edge, so a fresh write
    // becomes visible one cycle after it lands.
    always_ff @(posedge clk_160M) begin
        if (!nrst || !en) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_m_valid <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr_acc)       r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)           r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && w_full) r_ovf    <= 1'b1;
            r_count   <= w_count_nxt;
            r_m_valid <= (w_count_after_rd != '0);
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_valid ? w_head[15:0] : 16'h0000;
    assign m_last    = r_m_valid & w_head[16];
    assign line_done = r_line_done;
    assign line_err  = r_line_err;
    assign line_len  = r_line_len;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ccd_line_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccd_line_rx
// Description : Self-checking bench for ccd_line_rx: line scenario table plus
//               directed latency, overflow, abort, mid-line start and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccd_line_rx;

    logic        clk_160M = 1'b0;
    logic        nrst, en, pix_clk, pix_out_valid, m_ready;
    logic [11:0] exp_len;
    logic [15:0] pix_data, m_data;
    logic        m_last, m_valid, line_done, line_err, ovf;
    logic [11:0] line_len;

    int checks = 0;
    int errors = 0;
    int done_cnt, err_cnt, both_cnt;
    logic [16:0] rxq[$];
    logic        stall_prev = 1'b0;
    logic [16:0] hold;

    typedef struct {
        int exp_len; int n_valid; int beats; int lasts;
        int done;    int err;     int both;  int len;
    } vec_t;
    vec_t tbl[7];

    ccd_line_rx #(.FIFO_DEPTH(64), .LEN_W(12)) dut (
        .clk_160M(clk_160M), .nrst(nrst), .en(en), .exp_len(exp_len),
        .pix_clk(pix_clk), .pix_out_valid(pix_out_valid), .pix_data(pix_data),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .line_done(line_done), .line_err(line_err), .line_len(line_len), .ovf(ovf)
    );

    always #5 clk_160M = ~clk_160M;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_160M);
        #2;
    endtask

    // Data and valid change on the falling strobe edge, 4 cycles low / 4 high.
    task automatic send_pix(input logic v, input logic [15:0] d);
        pix_clk = 1'b0; pix_out_valid = v; pix_data = d;
        tick(4);
        pix_clk = 1'b1;
        tick(4);
    endtask

    task automatic clear_mon();
        rxq.delete();
        done_cnt = 0; err_cnt = 0; both_cnt = 0;
    endtask

    function automatic int data_bad();
        int bad = 0;
        for (int k = 0; k < rxq.size(); k++)
            if (rxq[k][15:0] != k[15:0]) bad++;
        return bad;
    endfunction

    function automatic int last_count();
        int n = 0;
        for (int k = 0; k < rxq.size(); k++)
            if (rxq[k][16]) n++;
        return n;
    endfunction

    always @(negedge clk_160M) begin
        if (line_done) done_cnt++;
        if (line_err) err_cnt++;
        if (line_done && line_err) both_cnt++;
        if (m_valid && m_ready) rxq.push_back({m_last, m_data});
        if (stall_prev && m_valid) chk("stall_hold", {m_last, m_data}, hold);
        stall_prev = m_valid && !m_ready;
        hold       = {m_last, m_data};
    end

    initial begin
        tbl[0] = '{2048, 2048, 2048, 1, 1, 0, 0, 2048};
        tbl[1] = '{2048, 2000, 2000, 0, 1, 1, 1, 2000};
        tbl[2] = '{4,    6,    4,    1, 1, 1, 0, 4};
        tbl[3] = '{0,    1,    1,    1, 1, 0, 0, 1};
        tbl[4] = '{0,    3,    1,    1, 1, 1, 0, 1};
        tbl[5] = '{5,    5,    5,    1, 1, 0, 0, 5};
        tbl[6] = '{10,   3,    3,    0, 1, 1, 1, 3};

        nrst = 1'b0; en = 1'b0; exp_len = 12'd0; pix_clk = 1'b0;
        pix_out_valid = 1'b0; pix_data = 16'h0; m_ready = 1'b0;
        clear_mon();
        tick(3);
        chk("reset_outputs", {m_data, m_last, m_valid, line_done, line_err, line_len, ovf}, 64'd0);
        nrst = 1'b1;

        // First-pixel latency: write/line_done at E+2, m_valid at E+3.
        en = 1'b1; exp_len = 12'd1;
        tick(2);
        send_pix(1'b0, 16'h0);
        pix_clk = 1'b0; pix_out_valid = 1'b1; pix_data = 16'h1234;
        tick(4);
        pix_clk = 1'b1;
        tick(1);
        chk("lat_E_valid", {m_valid, line_done}, 2'b00);
        tick(1);
        chk("lat_E1_done", line_done, 1'b0);
        tick(1);
        chk("lat_E2_done_len", {line_done, m_valid, line_len}, {1'b1, 1'b0, 12'd1});
        tick(1);
        chk("lat_E3_beat", {m_valid, m_last, m_data, line_done}, {1'b1, 1'b1, 16'h1234, 1'b0});
        tick(1);
        send_pix(1'b0, 16'h0);
        m_ready = 1'b1;
        tick(4);

        for (int i = 0; i < 7; i++) begin
            clear_mon();
            exp_len = 12'(tbl[i].exp_len);
            send_pix(1'b0, 16'h0);
            for (int p = 0; p < tbl[i].n_valid; p++) send_pix(1'b1, 16'(p));
            send_pix(1'b0, 16'h0);
            send_pix(1'b0, 16'h0);
            tick(10);
            chk($sformatf("v%0d_beats", i), rxq.size(), tbl[i].beats);
            chk($sformatf("v%0d_data", i), data_bad(), 0);
            chk($sformatf("v%0d_lasts", i), last_count(), tbl[i].lasts);
            if (rxq.size() > 0)
                chk($sformatf("v%0d_last_pos", i), rxq[rxq.size()-1][16], tbl[i].lasts != 0);
            chk($sformatf("v%0d_done", i), done_cnt, tbl[i].done);
            chk($sformatf("v%0d_err", i), err_cnt, tbl[i].err);
            chk($sformatf("v%0d_both", i), both_cnt, tbl[i].both);
            chk($sformatf("v%0d_len", i), line_len, tbl[i].len);
            chk($sformatf("v%0d_ovf", i), ovf, 1'b0);
        end

        // Backpressure and overflow: 64 entries fit, pixel 65 onward dropped.
        m_ready = 1'b0; exp_len = 12'd100;
        for (int p = 0; p < 70; p++) begin
            send_pix(1'b1, 16'(p));
            if (p == 63) chk("ovf_at_64", ovf, 1'b0);
            if (p == 64) chk("ovf_at_65", ovf, 1'b1);
        end
        chk("ovf_head_stable", {m_valid, m_data}, {1'b1, 16'h0});
        send_pix(1'b0, 16'h0);
        chk("ovf_line_len", line_len, 12'd70);
        clear_mon();
        m_ready = 1'b1;
        tick(80);
        chk("ovf_drain_beats", rxq.size(), 64);
        chk("ovf_drain_data", data_bad(), 0);

        // Abort mid-line: flush on the edge that samples en low.
        chk("abort_ovf_sticky", ovf, 1'b1);
        m_ready = 1'b0;
        for (int p = 0; p < 5; p++) send_pix(1'b1, 16'(p));
        chk("abort_pre_valid", m_valid, 1'b1);
        clear_mon();
        en = 1'b0;
        tick(1);
        chk("abort_flush", {m_valid, ovf}, 2'b00);
        tick(20);
        chk("abort_no_done", done_cnt, 0);

        // Enable while a line is in flight: wait for the gap.
        m_ready = 1'b1;
        clear_mon();
        send_pix(1'b1, 16'd200);
        en = 1'b1;
        for (int p = 0; p < 3; p++) send_pix(1'b1, 16'd201);
        exp_len = 12'd2;
        send_pix(1'b0, 16'h0);
        send_pix(1'b1, 16'd0);
        send_pix(1'b1, 16'd1);
        send_pix(1'b0, 16'h0);
        tick(10);
        chk("midstart_beats", rxq.size(), 2);
        chk("midstart_data", data_bad(), 0);
        chk("midstart_last", last_count(), 1);

        // One-cycle reset in the middle of a line.
        m_ready = 1'b0; exp_len = 12'd100;
        for (int p = 0; p < 3; p++) send_pix(1'b1, 16'(p + 7));
        chk("rst_pre_valid", m_valid, 1'b1);
        nrst = 1'b0;
        tick(1);
        chk("rst_mid_outputs", {m_data, m_last, m_valid, line_done, line_err, line_len, ovf}, 64'd0);
        nrst = 1'b1;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
